// File: rtl/lcd_pkg.sv
// lcd_pkg: state encoding, init command table and clear/home decode for the LCD controller
package lcd_pkg;
    typedef enum logic [2:0] {PWRUP, SETUP, PULSE, HOLD, WAIT, IDLE} lcd_state_e;
    localparam int INIT_N = 4;
    localparam logic [INIT_N-1:0][7:0] INIT_CMDS = {8'h06, 8'h01, 8'h0C, 8'h38};
    function automatic logic is_clr(input logic rs, input logic [7:0] data);
        return !rs && data[7:2] == 6'd0;
    endfunction
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter that stops at zero and flags it
module lcd_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);
    logic [W-1:0] cnt;
    always_ff @(posedge i_clk) begin
        if (i_load) cnt <= i_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign o_done = cnt == '0;
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 write-only controller with built-in power-up init and bus phase timing
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 4,
    parameter int T_EN    = 25,
    parameter int T_HOLD  = 4,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_vld,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_data,
    output logic       o_req_rdy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);
    localparam int T_MAX = max2(max2(max2(T_PWRUP, T_SETUP), max2(T_EN, T_HOLD)), max2(T_CMD, T_CLR));
    localparam int W = T_MAX > 1 ? $clog2(T_MAX) : 1;
    localparam logic [W-1:0] L_PWRUP = W'(T_PWRUP - 1);
    localparam logic [W-1:0] L_SETUP = W'(T_SETUP - 1);
    localparam logic [W-1:0] L_EN    = W'(T_EN - 1);
    localparam logic [W-1:0] L_HOLD  = W'(T_HOLD - 1);
    localparam logic [W-1:0] L_CMD   = W'(T_CMD - 1);
    localparam logic [W-1:0] L_CLR   = W'(T_CLR - 1);
    localparam logic [1:0] INIT_LAST = 2'(INIT_N - 1);
    lcd_state_e state;
    logic [1:0] idx;
    logic first, ld, done;
    logic [W-1:0] ld_val;
    // o_lcd_on is still low only in the first PWRUP cycle, which (re)loads the power-up count
    always_comb begin
        first = state == PWRUP && !o_lcd_on;
        ld = !i_rst_n || first || (state == IDLE ? i_req_vld : done);
        ld_val = (!i_rst_n || first) ? L_PWRUP :
                 state == SETUP ? L_EN :
                 state == PULSE ? L_HOLD :
                 state == HOLD  ? (is_clr(o_lcd_rs, o_lcd_data) ? L_CLR : L_CMD) : L_SETUP;
    end
    lcd_timer #(.W(W)) u_timer (
        .i_clk  (i_clk),
        .i_load (ld),
        .i_val  (ld_val),
        .o_done (done)
    );
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= PWRUP;
            idx         <= '0;
            o_req_rdy   <= 1'b0;
            o_init_done <= 1'b0;
            o_lcd_on    <= 1'b0;
            o_lcd_en    <= 1'b0;
            o_lcd_rs    <= 1'b0;
            o_lcd_data  <= '0;
        end else begin
            case (state)
                PWRUP: if (!o_lcd_on) o_lcd_on <= 1'b1;
                       else if (done) begin
                           state      <= SETUP;
                           o_lcd_data <= INIT_CMDS[0];
                       end
                SETUP: if (done) begin
                           state    <= PULSE;
                           o_lcd_en <= 1'b1;
                       end
                PULSE: if (done) begin
                           state    <= HOLD;
                           o_lcd_en <= 1'b0;
                       end
                HOLD:  if (done) state <= WAIT;
                WAIT:  if (done) begin
                           if (!o_init_done && idx != INIT_LAST) begin
                               idx        <= idx + 2'd1;
                               state      <= SETUP;
                               o_lcd_data <= INIT_CMDS[idx + 2'd1];
                           end else begin
                               state       <= IDLE;
                               o_req_rdy   <= 1'b1;
                               o_init_done <= 1'b1;
                           end
                       end
                IDLE:  if (i_req_vld) begin
                           state      <= SETUP;
                           o_req_rdy  <= 1'b0;
                           o_lcd_rs   <= i_req_rs;
                           o_lcd_data <= i_req_data;
                       end
                default: state <= PWRUP;
            endcase
        end
    end
    assign o_lcd_rw = 1'b0;
endmodule
